// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter:
// FSM states, access size codes and the size decode helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    // Byte select dominates halfword select; neither bit set means a word access.
    function automatic size_e size_code(input logic is_byte, input logic is_half);
        if (is_byte) return BYTE;
        if (is_half) return HALF;
        return WORD;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and shared memory port of the arbiter.
// Handshake: a requester raises req with its operands and holds them stable
// until the one-cycle ack; err is meaningful only while ack is high, and a req
// still high in the cycle after its ack counts as a new request.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic        if_err;
    logic [31:0] if_instr;

    logic        d_req;
    logic [31:0] d_addr;
    logic        d_we;
    logic        d_byte;
    logic        d_half;
    logic        d_sext;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;

    logic [31:0] mem_addr;
    logic        mem_write_enable;
    logic        mem_byte;
    logic        mem_half_word;
    logic        mem_sign_extend;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_err, if_instr,
        input  d_req, d_addr, d_we, d_byte, d_half, d_sext, d_wdata,
        output d_ack, d_err, d_rdata,
        output mem_addr, mem_write_enable, mem_byte, mem_half_word,
        output mem_sign_extend, mem_data_out,
        input  mem_data_in
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_err, if_instr,
        output d_req, d_addr, d_we, d_byte, d_half, d_sext, d_wdata,
        input  d_ack, d_err, d_rdata,
        input  mem_addr, mem_write_enable, mem_byte, mem_half_word,
        input  mem_sign_extend, mem_data_out,
        output mem_data_in
    );

endinterface

// File: rtl/mem_align_check.sv
// Flags an access whose address is misaligned for its size or lies beyond
// the end of memory. Purely combinational.
module mem_align_check
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 16384
) (
    input  logic [31:0] addr,
    input  size_e       size,
    output logic        err
);

    always_comb begin
        err = 1'b0;
        if (addr >= MEM_SIZE) err = 1'b1;
        case (size)
            HALF:    if (addr[0]) err = 1'b1;
            WORD:    if (addr[1:0] != 2'b00) err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction fetch port and a data port.
// Data normally wins; a bounded starvation counter eventually lets fetch through.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MEM_SIZE     = 16384
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus,
    output state_e             state_dbg
);

    localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      lat_addr_q, lat_addr_d;
    logic [31:0]      lat_wdata_q, lat_wdata_d;
    size_e            lat_size_q, lat_size_d;
    logic             lat_we_q, lat_we_d;
    logic             lat_sext_q, lat_sext_d;
    logic             lat_is_i_q, lat_is_i_d;
    logic             lat_err_q, lat_err_d;
    logic [31:0]      if_instr_q, if_instr_d;
    logic [31:0]      d_rdata_q, d_rdata_d;

    logic  if_bad, d_bad, fetch_win, data_win, in_grant;
    size_e d_size;

    assign d_size = size_code(bus.d_byte, bus.d_half);

    mem_align_check #(.MEM_SIZE(MEM_SIZE)) u_if_check (
        .addr (bus.if_addr),
        .size (WORD),
        .err  (if_bad)
    );

    mem_align_check #(.MEM_SIZE(MEM_SIZE)) u_d_check (
        .addr (bus.d_addr),
        .size (d_size),
        .err  (d_bad)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_size_d  = lat_size_q;
        lat_we_d    = lat_we_q;
        lat_sext_d  = lat_sext_q;
        lat_is_i_d  = lat_is_i_q;
        lat_err_d   = lat_err_q;
        if_instr_d  = if_instr_q;
        d_rdata_d   = d_rdata_q;
        fetch_win   = bus.if_req && (!bus.d_req || cnt_q == CNT_MAX);
        data_win    = bus.d_req && !fetch_win;

        case (state_q)
            IDLE: begin
                if (fetch_win) begin
                    lat_addr_d  = bus.if_addr;
                    lat_wdata_d = '0;
                    lat_size_d  = WORD;
                    lat_we_d    = 1'b0;
                    lat_sext_d  = 1'b0;
                    lat_is_i_d  = 1'b1;
                    lat_err_d   = if_bad;
                    cnt_d       = '0;
                    state_d     = if_bad ? RESP : GRANT_I;
                end else if (data_win) begin
                    lat_addr_d  = bus.d_addr;
                    lat_wdata_d = bus.d_wdata;
                    lat_size_d  = d_size;
                    lat_we_d    = bus.d_we;
                    lat_sext_d  = bus.d_sext;
                    lat_is_i_d  = 1'b0;
                    lat_err_d   = d_bad;
                    // Count only grants that actually made a waiting fetch wait.
                    if (!bus.if_req)          cnt_d = '0;
                    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                    state_d     = d_bad ? RESP : GRANT_D;
                end else begin
                    cnt_d = '0;
                end
            end
            GRANT_I: begin
                if_instr_d = bus.mem_data_in;
                state_d    = RESP;
            end
            GRANT_D: begin
                if (!lat_we_q) d_rdata_d = bus.mem_data_in;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_size_q  <= BYTE;
            lat_we_q    <= 1'b0;
            lat_sext_q  <= 1'b0;
            lat_is_i_q  <= 1'b0;
            lat_err_q   <= 1'b0;
            if_instr_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_size_q  <= lat_size_d;
            lat_we_q    <= lat_we_d;
            lat_sext_q  <= lat_sext_d;
            lat_is_i_q  <= lat_is_i_d;
            lat_err_q   <= lat_err_d;
            if_instr_q  <= if_instr_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign in_grant = (state_q == GRANT_I) || (state_q == GRANT_D);

    always_comb begin
        bus.mem_addr        = '0;
        bus.mem_data_out    = '0;
        bus.mem_byte        = 1'b0;
        bus.mem_half_word   = 1'b0;
        bus.mem_sign_extend = 1'b0;
        if (in_grant) begin
            bus.mem_addr        = lat_addr_q;
            bus.mem_data_out    = lat_wdata_q;
            bus.mem_byte        = (lat_size_q == BYTE);
            bus.mem_half_word   = (lat_size_q == HALF);
            bus.mem_sign_extend = lat_sext_q;
        end
    end

    // Reset must suppress the write even in the cycle the grant is aborted.
    assign bus.mem_write_enable = (state_q == GRANT_D) && lat_we_q && !reset;

    assign bus.if_ack   = (state_q == RESP) && lat_is_i_q;
    assign bus.if_err   = bus.if_ack && lat_err_q;
    assign bus.if_instr = if_instr_q;
    assign bus.d_ack    = (state_q == RESP) && !lat_is_i_q;
    assign bus.d_err    = bus.d_ack && lat_err_q;
    assign bus.d_rdata  = d_rdata_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares them as acks and writes appear.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic   clock = 1'b0;
    logic   reset;
    state_e state_dbg;
    int     cyc = 0;
    int     n_chk = 0;
    int     n_fail = 0;
    int     i_acks = 0;
    int     d_acks = 0;
    int     i_seen = 0;
    int     d_seen = 0;

    // {err, data, expected ack cycle}
    logic [64:0] exp_i_q[$];
    logic [64:0] exp_d_q[$];
    // {byte, half, addr, data}
    logic [65:0] exp_w_q[$];

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(4), .MEM_SIZE(16384)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h10) return 32'hac612000;
        return {~a[15:0], a[15:0]};
    endfunction

    assign bus.mem_data_in = mem_model(bus.mem_addr);

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue_fetch(input logic [31:0] addr, input int lat, input logic err,
                               input logic [31:0] instr);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        exp_i_q.push_back({err, instr, 32'(cyc + lat)});
    endtask

    task automatic issue_data(input logic [31:0] addr, input logic we, input logic byt,
                              input logic half, input logic sext, input logic [31:0] wdata,
                              input int lat, input logic err, input logic [31:0] rdata);
        bus.d_req   = 1'b1;
        bus.d_addr  = addr;
        bus.d_we    = we;
        bus.d_byte  = byt;
        bus.d_half  = half;
        bus.d_sext  = sext;
        bus.d_wdata = wdata;
        exp_d_q.push_back({err, rdata, 32'(cyc + lat)});
        if (we && !err) exp_w_q.push_back({byt, half, addr, wdata});
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (i_acks <= i_seen && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        if (i_acks <= i_seen) begin
            n_chk++; n_fail++;
            $display("FAIL fetch_timeout: no if_ack within 40 cycles (cycle %0d)", cyc);
        end
        i_seen = i_acks;
        bus.if_req = 1'b0;
    endtask

    task automatic wait_data();
        int n = 0;
        while (d_acks <= d_seen && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        if (d_acks <= d_seen) begin
            n_chk++; n_fail++;
            $display("FAIL data_timeout: no d_ack within 40 cycles (cycle %0d)", cyc);
        end
        d_seen = d_acks;
        bus.d_req = 1'b0;
    endtask

    // Monitor: responses, memory writes and idle-bus behaviour.
    always @(negedge clock) begin
        logic [64:0] e;
        logic [65:0] w;
        if (bus.if_ack) begin
            if (exp_i_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL if_ack_unexpected: got ack, required none (cycle %0d)", cyc);
            end else begin
                e = exp_i_q.pop_front();
                check("if_ack_cycle", 96'(cyc), 96'(e[31:0]));
                check("if_err", 96'(bus.if_err), 96'(e[64]));
                check("if_instr", 96'(bus.if_instr), 96'(e[63:32]));
            end
            i_acks++;
        end
        if (bus.d_ack) begin
            if (exp_d_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL d_ack_unexpected: got ack, required none (cycle %0d)", cyc);
            end else begin
                e = exp_d_q.pop_front();
                check("d_ack_cycle", 96'(cyc), 96'(e[31:0]));
                check("d_err", 96'(bus.d_err), 96'(e[64]));
                check("d_rdata", 96'(bus.d_rdata), 96'(e[63:32]));
            end
            d_acks++;
        end
        if (bus.mem_write_enable) begin
            if (exp_w_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL write_unexpected: addr %0h (cycle %0d)", bus.mem_addr, cyc);
            end else begin
                w = exp_w_q.pop_front();
                check("wr_addr", 96'(bus.mem_addr), 96'(w[63:32]));
                check("wr_data", 96'(bus.mem_data_out), 96'(w[31:0]));
                check("wr_size", 96'({bus.mem_byte, bus.mem_half_word}), 96'(w[65:64]));
            end
        end
        if (state_dbg != GRANT_I && state_dbg != GRANT_D) begin
            check("mem_idle_bus", {bus.mem_addr, bus.mem_data_out, 32'h0},
                  96'(0));
            check("mem_idle_strobes", 96'({bus.mem_write_enable, bus.mem_byte,
                  bus.mem_half_word, bus.mem_sign_extend}), 96'(0));
        end
    end

    initial begin
        logic [31:0] addrs [4];
        logic [31:0] rds   [4];
        addrs = '{32'h100, 32'h104, 32'h108, 32'h10c};
        rds   = '{32'hfeff0100, 32'hfefb0104, 32'hfef70108, 32'hfef3010c};

        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_addr = '0; bus.d_we = 1'b0; bus.d_byte = 1'b0;
        bus.d_half = 1'b0; bus.d_sext = 1'b0; bus.d_wdata = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        check("rst_state", 96'(state_dbg), 96'(IDLE));
        check("rst_acks", 96'({bus.if_ack, bus.if_err, bus.d_ack, bus.d_err}), 96'(0));
        check("rst_if_instr", 96'(bus.if_instr), 96'(0));
        check("rst_d_rdata", 96'(bus.d_rdata), 96'(0));

        // Plain fetch
        issue_fetch(32'h10, 2, 1'b0, 32'hac612000);
        wait_fetch();

        // Simultaneous requests: data first, fetch after
        issue_data(32'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2, 1'b0, 32'hdfff2000);
        issue_fetch(32'h20, 5, 1'b0, 32'hffdf0020);
        wait_data();
        wait_fetch();

        // Rejected accesses answer in one cycle and hold previous read data
        issue_fetch(32'h12, 1, 1'b1, 32'hffdf0020);
        wait_fetch();
        issue_fetch(32'h4000, 1, 1'b1, 32'hffdf0020);
        wait_fetch();
        issue_data(32'h2001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b1, 32'hdfff2000);
        wait_data();
        issue_data(32'h2002, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b1, 32'hdfff2000);
        wait_data();
        issue_data(32'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1, 1'b1, 32'hdfff2000);
        wait_data();
        issue_data(32'h3fff, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2, 1'b0, 32'hc0003fff);
        wait_data();

        // Stores
        issue_data(32'h2003, 1'b1, 1'b1, 1'b0, 1'b0, 32'h000000ab, 2, 1'b0, 32'hc0003fff);
        wait_data();
        issue_data(32'h2002, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00001234, 2, 1'b0, 32'hc0003fff);
        wait_data();
        issue_data(32'h2004, 1'b1, 1'b0, 1'b0, 1'b0, 32'hcafef00d, 2, 1'b0, 32'hc0003fff);
        wait_data();
        issue_data(32'h2005, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00005678, 1, 1'b1, 32'hc0003fff);
        wait_data();
        issue_data(32'h2002, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 2, 1'b0, 32'hdffd2002);
        wait_data();

        // Starvation: four data grants, then the held fetch must win
        issue_fetch(32'h40, 14, 1'b0, 32'hffbf0040);
        for (int i = 0; i < 4; i++) begin
            issue_data(addrs[i], 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2, 1'b0, rds[i]);
            wait_data();
        end
        issue_data(32'h110, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5, 1'b0, 32'hfeef0110);
        wait_fetch();
        wait_data();

        // Reset in the middle of a store grant
        bus.d_req = 1'b1; bus.d_addr = 32'h2008; bus.d_we = 1'b1;
        bus.d_byte = 1'b0; bus.d_half = 1'b0; bus.d_sext = 1'b0; bus.d_wdata = 32'h5555aaaa;
        @(posedge clock); #1;
        check("abort_in_grant_d", 96'(state_dbg), 96'(GRANT_D));
        reset = 1'b1;
        #1 check("abort_we_gated", 96'(bus.mem_write_enable), 96'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        check("abort_state", 96'(state_dbg), 96'(IDLE));
        check("abort_acks", 96'({bus.if_ack, bus.if_err, bus.d_ack, bus.d_err}), 96'(0));
        check("abort_if_instr", 96'(bus.if_instr), 96'(0));
        check("abort_d_rdata", 96'(bus.d_rdata), 96'(0));
        check("abort_mem_addr", 96'(bus.mem_addr), 96'(0));

        // Normal operation resumes
        issue_fetch(32'h8, 2, 1'b0, 32'hfff70008);
        wait_fetch();

        repeat (5) @(posedge clock);
        #1;
        check("fetch_q_empty", 96'(exp_i_q.size()), 96'(0));
        check("data_q_empty", 96'(exp_d_q.size()), 96'(0));
        check("write_q_empty", 96'(exp_w_q.size()), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive data grants while a fetch is pending.
REQ-002 SHALL have parameter MEM_SIZE, default 16384: memory size in bytes; addresses >= MEM_SIZE are out of range.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports if_req in 1, if_addr in 32: fetch request and byte address.
REQ-006 SHALL have ports if_ack out 1, if_err out 1, if_instr out 32: fetch completion pulse, error flag, instruction word.
REQ-007 SHALL have ports d_req in 1, d_addr in 32, d_we in 1, d_byte in 1, d_half in 1, d_sext in 1, d_wdata in 32: data request, address, store select, size select (neither size bit = word), load sign-extend, store data.
REQ-008 SHALL have ports d_ack out 1, d_err out 1, d_rdata out 32: data completion pulse, error flag, load data.
REQ-009 SHALL have ports mem_addr out 32, mem_write_enable out 1, mem_byte out 1, mem_half_word out 1, mem_sign_extend out 1, mem_data_out out 32: shared memory port (memory writes on rising edge).
REQ-010 SHALL have port mem_data_in  in  32  combinational read data from shared memory.

Function
REQ-011 SHALL implement FSM states IDLE, GRANT_I, GRANT_D, RESP.
REQ-012 In IDLE, SHALL sample requests; d_req wins over if_req unless starvation counter == STARVE_LIMIT and if_req high, then if_req wins.
REQ-013 On grant, SHALL latch the winner's address/controls/wdata and enter GRANT_I or GRANT_D next cycle.
REQ-014 In GRANT_x, SHALL drive mem_* from the latch; mem_write_enable=1 only in GRANT_D with d_we=1, for exactly that one cycle.
REQ-015 At end of GRANT_x, SHALL register mem_data_in into if_instr or d_rdata (loads/fetches only) and enter RESP.
REQ-016 In RESP, SHALL pulse the granted requester's ack for exactly one cycle, then return to IDLE; req-to-ack latency = 2 cycles.
REQ-017 Requesters hold req and operands stable until ack; a req still high in IDLE after its ack is treated as a new request.
REQ-018 Fetch with if_addr[1:0]!=0 or if_addr>=MEM_SIZE SHALL skip GRANT_I, go IDLE->RESP, assert if_ack and if_err; latency 1.
REQ-019 Data with halfword at odd address, word not 4-aligned, or address>=MEM_SIZE SHALL skip GRANT_D, go IDLE->RESP, assert d_ack and d_err, no memory write; latency 1.
REQ-020 Starvation counter (width clog2(STARVE_LIMIT+1)) SHALL increment on each data grant while if_req high, saturate at STARVE_LIMIT, clear on fetch grant or when if_req low at arbitration.
REQ-021 Outside GRANT_x, mem_addr, mem_data_out and all mem strobes SHALL be 0.
REQ-022 if_instr/d_rdata SHALL hold their last value until next completed access; err flags valid only with ack.

Reset
REQ-023 While reset high at a rising edge: state<=IDLE, counter<=0, latches<=0, if_instr<=0, d_rdata<=0.
REQ-024 mem_write_enable SHALL be gated by !reset so no write occurs in any cycle with reset high, including mid-GRANT_D.
REQ-025 After reset, all acks/errs 0 and the aborted request gets no ack; requester must re-request.

Structure
REQ-026 Package mem_arb_pkg SHALL hold FSM state encoding and size-code constants (BYTE, HALF, WORD).
REQ-027 Alignment/range check SHALL be sub-module mem_align_check (combinational, instanced for fetch and data).

Verification
REQ-028 Fetch if_addr=0x10, mem returns 0xac612000 -> if_ack at req+2, if_instr=0xac612000, if_err=0.
REQ-029 if_req and d_req (load word 0x2000) same cycle -> d_ack at +2, if_ack at +5.
REQ-030 d_req issued back-to-back, if_req held, STARVE_LIMIT=4 -> fetch granted immediately after the 4th data ack.
REQ-031 d_half=1, d_addr=0x2001 -> d_ack, d_err at +1; mem_write_enable never high.
REQ-032 Store byte d_addr=0x2003, d_wdata=0x000000AB -> one cycle mem_write_enable=1, mem_byte=1, mem_addr=0x2003.
REQ-033 reset high during GRANT_D store -> no write, next cycle IDLE, all outputs 0, no d_ack.
